// File: rtl/pc_gen_if.sv
// Fetch-side bus of the next-PC generator: fetch handshake, BTB prediction,
// redirect sources from memory/interrupt/execute, and the flush indication.
interface pc_gen_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic            fetch_ready;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            csr_flush;
  logic [XLEN-1:0] csr_pc;
  logic            mret;
  logic [XLEN-1:0] mepc;
  logic            exception;
  logic            irq;
  logic [XLEN-1:0] mtvec;
  logic            br_valid;
  logic [XLEN-1:0] br_pc;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            br_pred_taken;
  logic [XLEN-1:0] br_pred_target;
  logic            flush;

  modport master (
    output pc_out, pc_valid, pred_taken, pred_target, flush,
    input  fetch_ready, csr_flush, csr_pc, mret, mepc, exception, irq, mtvec,
           br_valid, br_pc, br_taken, br_target, br_pred_taken, br_pred_target
  );

  modport slave (
    input  pc_out, pc_valid, pred_taken, pred_target, flush,
    output fetch_ready, csr_flush, csr_pc, mret, mepc, exception, irq, mtvec,
           br_valid, br_pc, br_taken, br_target, br_pred_taken, br_pred_target
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage next-PC generator: owns the fetch PC, arbitrates redirects and
// predicts the next PC with a direct-mapped branch target buffer.
module pc_gen #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(64'h8000_0000),
  parameter int              INST_BYTES  = 4,
  parameter int              BTB_ENTRIES = 16
) (
  input logic       clk,
  input logic       reset,
  pc_gen_if.master  bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INST_BYTES);
  endfunction

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic             pc_valid_q;
  logic [XLEN-1:0]  redir_tgt;
  logic             trap_redir;
  logic             mispredict;
  logic             flush_c;
  logic             btb_wr;

  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             hit;

  assign rd_idx = pc_q[IDX_W+1:2];
  assign rd_tag = pc_q[XLEN-1:IDX_W+2];
  assign wr_idx = bus.br_pc[IDX_W+1:2];
  assign wr_tag = bus.br_pc[XLEN-1:IDX_W+2];
  assign hit    = btb_vld[rd_idx] && (btb_tag[rd_idx] == rd_tag);

  assign trap_redir = bus.csr_flush || bus.mret || bus.exception || bus.irq;
  assign mispredict = bus.br_valid &&
                      ((bus.br_taken != bus.br_pred_taken) ||
                       (bus.br_taken && (bus.br_pred_target != bus.br_target)));
  assign flush_c    = reset && (trap_redir || mispredict);
  // A branch squashed by an older-stage redirect must not train the BTB.
  assign btb_wr     = bus.br_valid && !trap_redir;

  always_comb begin
    redir_tgt = pc_step(bus.csr_pc);
    if (bus.csr_flush)                   redir_tgt = pc_step(bus.csr_pc);
    else if (bus.mret)                   redir_tgt = bus.mepc;
    else if (bus.exception || bus.irq)   redir_tgt = bus.mtvec;
    else if (bus.br_taken)               redir_tgt = bus.br_target;
    else                                 redir_tgt = pc_step(bus.br_pc);
  end

  always_comb begin
    pc_d = pc_q;
    if (flush_c)                             pc_d = redir_tgt;
    else if (pc_valid_q && bus.fetch_ready)  pc_d = hit ? btb_tgt[rd_idx] : pc_step(pc_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      btb_vld    <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      if (btb_wr) begin
        if (bus.br_taken)                    btb_vld[wr_idx] <= 1'b1;
        else if (btb_tag[wr_idx] == wr_tag)  btb_vld[wr_idx] <= 1'b0;
      end
    end
  end

  // Tag/target payload carries no reset; the valid bits gate its use.
  always_ff @(posedge clk) begin
    if (btb_wr && bus.br_taken) begin
      btb_tag[wr_idx] <= wr_tag;
      btb_tgt[wr_idx] <= bus.br_target;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.pred_taken  = hit;
  assign bus.pred_target = btb_tgt[rd_idx];
  assign bus.flush       = flush_c;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the fetch PC and branch target buffer.
module tb_pc_gen;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(64)) bus ();

  pc_gen #(.XLEN(64), .RESET_PC(RST_PC), .INST_BYTES(4), .BTB_ENTRIES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: each BTB slot remembers the word address of the branch that trained it.
  logic [63:0] m_pc;
  bit          m_valid;
  bit          m_v    [16];
  logic [61:0] m_word [16];
  logic [63:0] m_tgt  [16];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 2) % 64'd16);
  endfunction

  function automatic bit m_hit(input logic [63:0] pc);
    int i = idx_of(pc);
    return m_v[i] && (m_word[i] == pc[63:2]);
  endfunction

  function automatic bit m_trap();
    return bus.csr_flush || bus.mret || bus.exception || bus.irq;
  endfunction

  function automatic bit m_mis();
    if (!bus.br_valid) return 1'b0;
    if (bus.br_taken != bus.br_pred_taken) return 1'b1;
    return bus.br_taken && (bus.br_target != bus.br_pred_target);
  endfunction

  function automatic logic [63:0] m_redir();
    if (bus.csr_flush) return bus.csr_pc + 64'd4;
    if (bus.mret) return bus.mepc;
    if (bus.exception || bus.irq) return bus.mtvec;
    if (bus.br_taken) return bus.br_target;
    return bus.br_pc + 64'd4;
  endfunction

  task automatic model_reset();
    m_pc    = RST_PC;
    m_valid = 1'b0;
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
  endtask

  task automatic clr_in();
    bus.csr_flush = 0; bus.csr_pc = '0; bus.mret = 0; bus.mepc = '0;
    bus.exception = 0; bus.irq = 0; bus.mtvec = '0;
    bus.br_valid = 0; bus.br_pc = '0; bus.br_taken = 0; bus.br_target = '0;
    bus.br_pred_taken = 0; bus.br_pred_target = '0;
  endtask

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit          fl;
    bit          h;
    logic [63:0] tgt;
    int          i;
    @(negedge clk);
    fl  = m_trap() || m_mis();
    h   = m_hit(m_pc);
    tgt = m_redir();
    check_val("pc_out", bus.pc_out, m_pc);
    check_val("pc_valid", 64'(bus.pc_valid), 64'(m_valid));
    check_val("pred_taken", 64'(bus.pred_taken), 64'(h));
    if (h) check_val("pred_target", bus.pred_target, m_tgt[idx_of(m_pc)]);
    check_val("flush", 64'(bus.flush), 64'(fl));
    @(posedge clk);
    if (fl) m_pc = tgt;
    else if (m_valid && bus.fetch_ready) m_pc = h ? m_tgt[idx_of(m_pc)] : m_pc + 64'd4;
    m_valid = 1'b1;
    if (bus.br_valid && !m_trap()) begin
      i = idx_of(bus.br_pc);
      if (bus.br_taken) begin
        m_v[i] = 1'b1; m_word[i] = bus.br_pc[63:2]; m_tgt[i] = bus.br_target;
      end else if (m_word[i][61:4] == bus.br_pc[63:6]) begin
        m_v[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    clr_in();
    bus.mret = 1; bus.mepc = pc;
    tick();
    clr_in();
  endtask

  task automatic set_br(input logic [63:0] pc, input bit tk, input logic [63:0] tgt,
                        input bit ptk, input logic [63:0] ptgt);
    bus.br_valid = 1; bus.br_pc = pc; bus.br_taken = tk; bus.br_target = tgt;
    bus.br_pred_taken = ptk; bus.br_pred_target = ptgt;
  endtask

  function automatic logic [63:0] rnd_pc();
    return 64'h8000_0000 + 64'(4 * $urandom_range(0, 255));
  endfunction

  initial begin
    int i;
    reset = 1'b0;
    bus.fetch_ready = 1'b1;
    clr_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pc", bus.pc_out, RST_PC);
    check_val("rst_valid", 64'(bus.pc_valid), 64'd0);
    check_val("rst_flush", 64'(bus.flush), 64'd0);
    reset = 1'b1;

    tick();
    check_val("first_pc", bus.pc_out, 64'h8000_0000);
    check_val("first_valid", 64'(bus.pc_valid), 64'd1);
    tick(); check_val("seq_pc4", bus.pc_out, 64'h8000_0004);
    tick(); check_val("seq_pc8", bus.pc_out, 64'h8000_0008);
    tick(); tick();
    check_val("seq_pc10", bus.pc_out, 64'h8000_0010);
    bus.fetch_ready = 1'b0;
    repeat (3) tick();
    check_val("stall_hold", bus.pc_out, 64'h8000_0010);
    bus.fetch_ready = 1'b1;
    tick(); check_val("stall_release", bus.pc_out, 64'h8000_0014);

    set_br(64'h8000_0020, 1, 64'h8000_0100, 0, '0);
    #1 check_val("mispred_flush", 64'(bus.flush), 64'd1);
    tick(); clr_in();
    check_val("mispred_tgt", bus.pc_out, 64'h8000_0100);
    redirect_to(64'h8000_0020);
    check_val("btb_hit", 64'(bus.pred_taken), 64'd1);
    check_val("btb_tgt", bus.pred_target, 64'h8000_0100);
    tick(); check_val("follow_pred", bus.pc_out, 64'h8000_0100);

    bus.csr_flush = 1; bus.csr_pc = 64'h8000_0040;
    bus.exception = 1; bus.mtvec = 64'h8000_0200;
    set_br(64'h8000_0060, 1, 64'h8000_0300, 0, '0);
    tick(); clr_in();
    check_val("csr_prio", bus.pc_out, 64'h8000_0044);
    redirect_to(64'h8000_0020);
    check_val("btb_kept", 64'(bus.pred_taken), 64'd1);
    redirect_to(64'h8000_0060);
    check_val("squash_no_train", 64'(bus.pred_taken), 64'd0);

    set_br(64'h8000_0020, 0, '0, 1, 64'h8000_0100);
    tick(); clr_in();
    check_val("nt_fallthru", bus.pc_out, 64'h8000_0024);
    redirect_to(64'h8000_0020);
    check_val("nt_invalidated", 64'(bus.pred_taken), 64'd0);

    set_br(64'h8000_0020, 1, 64'h8000_0100, 0, '0); tick(); clr_in();
    set_br(64'h8000_0060, 1, 64'h8000_0200, 0, '0); tick(); clr_in();
    redirect_to(64'h8000_0020);
    check_val("alias_evict", 64'(bus.pred_taken), 64'd0);
    redirect_to(64'h8000_0060);
    check_val("alias_hit", 64'(bus.pred_taken), 64'd1);
    check_val("alias_tgt", bus.pred_target, 64'h8000_0200);

    bus.fetch_ready = 1'b0;
    bus.irq = 1; bus.mtvec = 64'h8000_0300;
    set_br(64'h8000_0030, 1, 64'h8000_0500, 0, '0);
    tick(); clr_in();
    check_val("irq_wins", bus.pc_out, 64'h8000_0300);
    redirect_to(64'h8000_0030);
    check_val("irq_no_train", 64'(bus.pred_taken), 64'd0);

    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    bus.fetch_ready = 1'b1;
    tick(); check_val("wrap", bus.pc_out, 64'h0);

    bus.fetch_ready = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_val("mid_rst_pc", bus.pc_out, RST_PC);
    check_val("mid_rst_valid", 64'(bus.pc_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    redirect_to(64'h8000_0060);
    check_val("rst_btb_clear", 64'(bus.pred_taken), 64'd0);

    for (int n = 0; n < 600; n++) begin
      clr_in();
      bus.fetch_ready = ($urandom_range(0, 3) != 0);
      bus.csr_flush   = ($urandom_range(0, 19) == 0); bus.csr_pc = rnd_pc();
      bus.mret        = ($urandom_range(0, 24) == 0); bus.mepc   = rnd_pc();
      bus.exception   = ($urandom_range(0, 24) == 0);
      bus.irq         = ($urandom_range(0, 24) == 0); bus.mtvec  = rnd_pc();
      if ($urandom_range(0, 2) == 0) begin
        bus.br_valid  = 1;
        bus.br_pc     = rnd_pc();
        bus.br_taken  = $urandom_range(0, 1);
        bus.br_target = rnd_pc();
        i = idx_of(bus.br_pc);
        if ($urandom_range(0, 3) != 0) begin
          bus.br_pred_taken  = m_hit(bus.br_pc);
          bus.br_pred_target = m_tgt[i];
          if ($urandom_range(0, 1) == 0) bus.br_target = m_tgt[i];
        end else begin
          bus.br_pred_taken  = $urandom_range(0, 1);
          bus.br_pred_target = rnd_pc();
        end
      end
      tick();
    end
    clr_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
